fusion_unit: RTL and testbench
==============================

Name: fusion_unit

Overview:
- Bit-Fusion-style fusion unit, built from 16 BitBricks (2b x 2b multipliers with signed/unsigned operands).
- Computes one product of a variable-precision input activation and a variable-precision weight.
- Supported precisions: 1, 2, 4 or 8 bits per operand, each signed or unsigned.
- Sits in a systolic PE array; the registered result is forwarded as a partial sum to the neighbouring unit.

Parameters:
- None. Datapath is fixed: 8-bit operands, 16-bit result.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in  input  8  input activation; operand occupies bits [in_width-1:0].
- weight  input  8  weight; operand occupies bits [weight_width-1:0].
- in_width  input  4  input precision in bits: 1, 2, 4 or 8.
- weight_width  input  4  weight precision in bits: 1, 2, 4 or 8.
- s_in  input  1  1 = input operand is two's complement; 0 = unsigned.
- s_weight  input  1  1 = weight operand is two's complement; 0 = unsigned.
- psum_fwd  output  16  registered product, two's complement or unsigned, truncated to 16 bits.

Behaviour:
- Operand extraction:
  - Input operand A = in[in_width-1:0].
  - Weight operand W = weight[weight_width-1:0].
  - Bits above the selected width are ignored and may hold any value.
- Width decode: any width code other than 1, 2, 4 or 8 is treated as 8.
- Sign handling:
  - Signed flag set and width >= 2: the operand MSB is the sign bit and the operand is sign-extended.
  - Otherwise the operand is zero-extended.
  - Width 1 is always unsigned (values 0/1), regardless of the s_* flag.
- Arithmetic:
  - P = ext(A) * ext(W), computed exactly, then truncated to 16 bits.
  - Full range: signed -128*-128 = 16384; unsigned 255*255 = 65025 (0xFE01); mixed 255*-128 = -32640 (0x8080).
- Microarchitecture:
  - Split each operand into four 2-bit slices.
  - Only the top slice of a signed operand is signed; lower slices are unsigned.
  - Form the 16 slice products, each as a 3b x 3b signed multiply in a BitBrick.
  - Shift each slice product by 2*(i+j) and sum into the 16-bit result.
  - Slices above the active width contribute zero.
- Timing:
  - Product path is combinational from inputs; the result is registered.
  - psum_fwd updates on every rising clk edge with the product of the inputs sampled at that edge, so latency is 1 cycle.
  - Throughput is one product per cycle; there is no handshake.
- Reset:
  - rst=1 at a clock edge sets psum_fwd to 16'h0000.
  - Reset has priority over the new product.
  - Reset mid-stream discards the in-flight product.
  - The first valid output appears one edge after rst deasserts with inputs applied.
- Width/sign changes take effect on the next edge with no pipeline flush.

Optional Feature:
- Macro: FUSION_UNIT_PSUM_ACC_EN.
- Defined:
  - Adds input port psum_in [15:0].
  - psum_fwd <= psum_in + P, with the sum truncated to 16 bits (modulo 2^16 wrap).
  - Reset value is still 0.
- Undefined:
  - No psum_in port.
  - psum_fwd <= P.

Test Plan:
- Reset:
  - rst=1 with in=8'hFF, weight=8'hFF, widths 8/8, unsigned.
  - psum_fwd must be 0x0000 after the edge.
  - Release rst; next edge must give 0xFE01.
- Unsigned sweep, every width pair in {1,2,4,8}^2:
  - Exhaustive A, W with s_in=s_weight=0.
  - psum_fwd = A*W one cycle later, e.g. widths 2/8, A=3, W=255 -> 765.
- Signed 8x8 exhaustive, -128..127 both operands:
  - -128*-128 -> 0x4000.
  - 127*-128 -> 0xC080.
  - -1*-1 -> 0x0001.
- Mixed sign and width:
  - s_in=1, in_width=4, in=4'b1000 (-8); s_weight=0, weight_width=8, weight=255 -> -2040 (0xF808).
  - Sweep all combos of widths 2/4/8 with signed 2- and 4-bit operands, e.g. 2b -2 * 4b 7 -> 0xFFF2.
- Ignored upper bits:
  - in_width=4, in=8'hA3 (operand 3), weight_width=2, weight=8'hFE (operand 2), unsigned -> 6.
  - Same inputs with s_weight=1 -> 3*-2 = 0xFFFA.
- Back-to-back streaming:
  - New operands every cycle; each psum_fwd must match the product of the previous cycle's inputs, with no bubbles.
  - With FUSION_UNIT_PSUM_ACC_EN: psum_in=0xFFFF, P=1 -> 0x0000 (wrap).

Source files
------------

// File: rtl/fusion_unit.sv
// Bit-Fusion fusion unit: 16 BitBricks form a variable-precision (1/2/4/8-bit) product, registered as psum_fwd.
// Optional macro FUSION_UNIT_PSUM_ACC_EN adds psum_in and accumulates it into the registered result.

module bit_brick (
  input  logic signed [2:0] a,
  input  logic signed [2:0] b,
  output logic signed [5:0] p
);
  assign p = a * b;
endmodule

module fusion_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  in,
  input  logic [7:0]  weight,
  input  logic [3:0]  in_width,
  input  logic [3:0]  weight_width,
  input  logic        s_in,
  input  logic        s_weight,
`ifdef FUSION_UNIT_PSUM_ACC_EN
  input  logic [15:0] psum_in,
`endif
  output logic [15:0] psum_fwd
);

  // Unsupported width codes fall back to full 8-bit precision.
  function automatic logic [3:0] decode_width(input logic [3:0] code);
    case (code)
      4'd1, 4'd2, 4'd4: return code;
      default:          return 4'd8;
    endcase
  endfunction

  function automatic logic [7:0] width_mask(input logic [3:0] w);
    case (w)
      4'd1:    return 8'h01;
      4'd2:    return 8'h03;
      4'd4:    return 8'h0F;
      default: return 8'hFF;
    endcase
  endfunction

  function automatic logic [1:0] top_slice(input logic [3:0] w);
    case (w)
      4'd2:    return 2'd0;
      4'd4:    return 2'd1;
      default: return 2'd3;
    endcase
  endfunction

  logic [3:0]  in_w;
  logic [3:0]  wt_w;
  logic [7:0]  a_op;
  logic [7:0]  w_op;
  logic        a_sgn;
  logic        w_sgn;
  logic [1:0]  a_top;
  logic [1:0]  w_top;
  logic [15:0] product;
  logic [15:0] next_psum;

  logic signed [2:0] a_sl [4];
  logic signed [2:0] w_sl [4];
  logic signed [5:0] pp   [4][4];

  assign in_w  = decode_width(in_width);
  assign wt_w  = decode_width(weight_width);
  assign a_op  = in & width_mask(in_w);
  assign w_op  = weight & width_mask(wt_w);
  assign a_sgn = s_in && (in_w != 4'd1);
  assign w_sgn = s_weight && (wt_w != 4'd1);
  assign a_top = top_slice(in_w);
  assign w_top = top_slice(wt_w);

  // Only the operand's top slice carries a sign bit; masked-off slices are zero.
  for (genvar k = 0; k < 4; k++) begin : g_slice
    assign a_sl[k] = {a_sgn && (a_top == 2'(k)) && a_op[2*k+1], a_op[2*k+1:2*k]};
    assign w_sl[k] = {w_sgn && (w_top == 2'(k)) && w_op[2*k+1], w_op[2*k+1:2*k]};
  end

  for (genvar i = 0; i < 4; i++) begin : g_row
    for (genvar j = 0; j < 4; j++) begin : g_col
      bit_brick u_bb (
        .a(a_sl[i]),
        .b(w_sl[j]),
        .p(pp[i][j])
      );
    end
  end

  // Sign-extend each slice product, weight it by its slice position and sum modulo 2^16.
  always_comb begin
    product = '0;
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        product = product + ({{10{pp[i][j][5]}}, pp[i][j]} << (2 * (i + j)));
      end
    end
  end

`ifdef FUSION_UNIT_PSUM_ACC_EN
  assign next_psum = psum_in + product;
`else
  assign next_psum = product;
`endif

  always_ff @(posedge clk) begin
    if (rst) psum_fwd <= '0;
    else     psum_fwd <= next_psum;
  end

endmodule

// File: tb/tb_fusion_unit.sv
// Self-checking bench for fusion_unit: directed hand-computed vectors plus model-checked sweeps.
// Build with FUSION_UNIT_PSUM_ACC_EN defined to also exercise the psum_in accumulation path.

module tb_fusion_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  in_v;
  logic [7:0]  weight_v;
  logic [3:0]  in_width;
  logic [3:0]  weight_width;
  logic        s_in;
  logic        s_weight;
  logic [15:0] psum_in;
  logic [15:0] psum_fwd;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  fusion_unit dut (
    .clk(clk),
    .rst(rst),
    .in(in_v),
    .weight(weight_v),
    .in_width(in_width),
    .weight_width(weight_width),
    .s_in(s_in),
    .s_weight(s_weight),
`ifdef FUSION_UNIT_PSUM_ACC_EN
    .psum_in(psum_in),
`endif
    .psum_fwd(psum_fwd)
  );

  // Reference: plain integer arithmetic on the extracted, extended operands.
  function automatic int ext_operand(input logic [7:0] raw, input logic [3:0] code, input logic sgn);
    int w;
    int v;
    w = (code == 4'd1 || code == 4'd2 || code == 4'd4) ? int'(code) : 8;
    v = int'(raw) & ((1 << w) - 1);
    if (sgn && w >= 2 && v >= (1 << (w - 1))) v = v - (1 << w);
    return v;
  endfunction

  function automatic logic [15:0] model(input logic [7:0] a, input logic [7:0] b,
                                        input logic [3:0] aw, input logic [3:0] bw,
                                        input logic as, input logic bs, input logic [15:0] acc);
    int p;
    logic [15:0] r;
    p = ext_operand(a, aw, as) * ext_operand(b, bw, bs);
    r = p[15:0];
`ifdef FUSION_UNIT_PSUM_ACC_EN
    r = r + acc;
`else
    if (acc != 16'h0) r = r;
`endif
    return r;
  endfunction

  task automatic checkOutput(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%04h expected 0x%04h", tag, got, exp);
    end
  endtask

  // Drive one operand set and advance exactly one clock edge; outputs are sampled 1ns later.
  task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b,
                               input logic [3:0] aw, input logic [3:0] bw,
                               input logic as, input logic bs);
    in_v = a;
    weight_v = b;
    in_width = aw;
    weight_width = bw;
    s_in = as;
    s_weight = bs;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] junk_upper(input int v, input int w);
    logic [7:0] m;
    m = (w >= 8) ? 8'hFF : 8'((1 << w) - 1);
    return (8'(v) & m) | (8'($urandom) & ~m);
  endfunction

  int widths [4] = '{1, 2, 4, 8};
  int swidths [3] = '{2, 4, 8};

  initial begin
    logic [7:0] a;
    logic [7:0] b;
    logic [15:0] exp;
    psum_in = 16'h0000;
    rst = 1'b1;
    applyStimulus(8'hFF, 8'hFF, 4'd8, 4'd8, 1'b0, 1'b0);
    checkOutput("reset", psum_fwd, 16'h0000);
    rst = 1'b0;
    applyStimulus(8'hFF, 8'hFF, 4'd8, 4'd8, 1'b0, 1'b0);
    checkOutput("first_after_reset", psum_fwd, 16'hFE01);

    applyStimulus(8'h03, 8'hFF, 4'd2, 4'd8, 1'b0, 1'b0);
    checkOutput("u_2x8_3x255", psum_fwd, 16'd765);
    applyStimulus(8'h80, 8'h80, 4'd8, 4'd8, 1'b1, 1'b1);
    checkOutput("s_min_x_min", psum_fwd, 16'h4000);
    applyStimulus(8'h7F, 8'h80, 4'd8, 4'd8, 1'b1, 1'b1);
    checkOutput("s_127_x_min", psum_fwd, 16'hC080);
    applyStimulus(8'hFF, 8'hFF, 4'd8, 4'd8, 1'b1, 1'b1);
    checkOutput("s_m1_x_m1", psum_fwd, 16'h0001);
    applyStimulus(8'hFF, 8'h80, 4'd8, 4'd8, 1'b0, 1'b1);
    checkOutput("mixed_255_x_min", psum_fwd, 16'h8080);
    applyStimulus(8'h08, 8'hFF, 4'd4, 4'd8, 1'b1, 1'b0);
    checkOutput("mixed_4b_m8_x_255", psum_fwd, 16'hF808);
    applyStimulus(8'h02, 8'h07, 4'd2, 4'd4, 1'b1, 1'b1);
    checkOutput("s_2b_m2_x_4b_7", psum_fwd, 16'hFFF2);
    applyStimulus(8'hA3, 8'hFE, 4'd4, 4'd2, 1'b0, 1'b0);
    checkOutput("upper_bits_unsigned", psum_fwd, 16'd6);
    applyStimulus(8'hA3, 8'hFE, 4'd4, 4'd2, 1'b0, 1'b1);
    checkOutput("upper_bits_signed_w", psum_fwd, 16'hFFFA);
    applyStimulus(8'hFF, 8'h7F, 4'd1, 4'd8, 1'b1, 1'b1);
    checkOutput("width1_ignores_sign", psum_fwd, 16'h007F);
    applyStimulus(8'hFF, 8'h02, 4'd3, 4'd8, 1'b0, 1'b0);
    checkOutput("width_code3_as_8", psum_fwd, 16'h01FE);

    // Mid-stream reset discards the product presented on the reset edge.
    rst = 1'b1;
    applyStimulus(8'h55, 8'h66, 4'd8, 4'd8, 1'b0, 1'b0);
    checkOutput("reset_mid_stream", psum_fwd, 16'h0000);
    rst = 1'b0;

    // Unsigned sweep over every width pair; 8-bit operands are strided to bound run time.
    foreach (widths[wi]) foreach (widths[wj]) begin
      for (int av = 0; av < (1 << widths[wi]); av += (widths[wi] == 8) ? 15 : 1) begin
        for (int bv = 0; bv < (1 << widths[wj]); bv += (widths[wj] == 8) ? 15 : 1) begin
          a = junk_upper(av, widths[wi]);
          b = junk_upper(bv, widths[wj]);
          applyStimulus(a, b, 4'(widths[wi]), 4'(widths[wj]), 1'b0, 1'b0);
          checkOutput("unsigned_sweep", psum_fwd, 16'((av * bv) & 16'hFFFF));
        end
      end
    end

    // Signed/mixed sweep over widths 2/4/8 for every sign combination.
    for (int sc = 0; sc < 4; sc++) begin
      foreach (swidths[wi]) foreach (swidths[wj]) begin
        for (int av = 0; av < (1 << swidths[wi]); av += (swidths[wi] == 8) ? 15 : 1) begin
          for (int bv = 0; bv < (1 << swidths[wj]); bv += (swidths[wj] == 8) ? 15 : 1) begin
            a = junk_upper(av, swidths[wi]);
            b = junk_upper(bv, swidths[wj]);
            applyStimulus(a, b, 4'(swidths[wi]), 4'(swidths[wj]), sc[0], sc[1]);
            exp = model(a, b, 4'(swidths[wi]), 4'(swidths[wj]), sc[0], sc[1], psum_in);
            checkOutput("signed_sweep", psum_fwd, exp);
          end
        end
      end
    end

    // Back-to-back stream with random operands and settings; one result per edge.
    for (int n = 0; n < 64; n++) begin
      a = 8'($urandom);
      b = 8'($urandom);
      in_width = 4'($urandom_range(0, 15));
      weight_width = 4'($urandom_range(0, 15));
      applyStimulus(a, b, in_width, weight_width, 1'($urandom), 1'($urandom));
      exp = model(a, b, in_width, weight_width, s_in, s_weight, psum_in);
      checkOutput("stream", psum_fwd, exp);
    end

`ifdef FUSION_UNIT_PSUM_ACC_EN
    psum_in = 16'hFFFF;
    applyStimulus(8'h01, 8'h01, 4'd8, 4'd8, 1'b0, 1'b0);
    checkOutput("acc_wrap", psum_fwd, 16'h0000);
    psum_in = 16'h1234;
    applyStimulus(8'h80, 8'h80, 4'd8, 4'd8, 1'b1, 1'b1);
    checkOutput("acc_add", psum_fwd, 16'h5234);
    rst = 1'b1;
    applyStimulus(8'h01, 8'h01, 4'd8, 4'd8, 1'b0, 1'b0);
    checkOutput("acc_reset", psum_fwd, 16'h0000);
    rst = 1'b0;
    psum_in = 16'h0000;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
